mc_rr_mem: RTL and testbench
============================

Name: mc_rr_mem

Overview:
- Parametrised multi-channel memory controller: single-port register-array memory shared by NUM_CH requesters.
- Round-robin arbitration, per-byte write enables, registered read responses.
- Hardware init sweep after reset fills the array with INIT_VAL.
- Sits between bus-side masters (DMA, CPU port) and local storage in the memory subsystem.

Parameters:
- ADDR_WIDTH, 4, word address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- NUM_CH, 2, number of requesting channels, 1..8.
- INIT_VAL, all-ones, word value written by the init sweep.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req  in  NUM_CH  per-channel request, held until granted
- we  in  NUM_CH  per-channel write (1) / read (0)
- addr  in  NUM_CH*ADDR_WIDTH  per-channel word address, channel i at slice i
- wdata  in  NUM_CH*DATA_WIDTH  per-channel write data
- be  in  NUM_CH*(DATA_WIDTH/8)  per-channel byte enables, writes only
- gnt  out  NUM_CH  one-hot grant, combinational, valid while a request is pending
- rvalid  out  NUM_CH  per-channel read-data-valid pulse
- rdata  out  DATA_WIDTH  read data, shared by all channels and qualified by rvalid
- init_done  out  1  high once the init sweep completes

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset values:
  - gnt=0, rvalid=0, rdata=0, init_done=0.
  - Round-robin pointer = channel 0.
  - Init counter = 0, FSM = INIT.
  - Memory contents are not reset directly.
- FSM states:
  - INIT: writes INIT_VAL to address init_cnt each cycle and increments init_cnt.
    - At init_cnt = 2**ADDR_WIDTH-1, the write occurs and the FSM goes to RUN.
    - The sweep takes exactly 2**ADDR_WIDTH cycles.
    - gnt stays 0 in INIT; requests are held off, not dropped.
  - RUN: init_done=1. No exit except reset.
- Arbitration in RUN:
  - gnt is one-hot, given to the first requesting channel at or after the rr pointer, searching upward with modulo wrap.
  - A grant completes the transfer in that same clock edge.
  - The pointer then moves to granted index +1, wrapping to 0 after NUM_CH-1.
  - No request pending: gnt=0 and the pointer holds.
  - Requesters must drop or change req in the cycle after gnt. Keeping req high means a new request.
- Write:
  - On the granted edge, each byte k with be[k]=1 is written from wdata.
  - Bytes with be[k]=0 keep their old value.
  - be=0 is a legal no-op and still consumes the grant.
- Read:
  - On the granted edge, rdata <= mem[addr] and rvalid[ch] <= 1 for exactly one cycle.
  - Read latency is 1 cycle after grant.
  - When rvalid is 0, rdata holds its last value.
- Back-to-back accesses:
  - A write to address A at cycle N, then a read of A at N+1, returns the new data.
  - A read and a write cannot be granted in the same cycle (single port).
- Reset mid-operation: all outputs return to reset values immediately.
  - Any pending rvalid is lost.
  - The init sweep restarts from address 0.
- NUM_CH=1: the arbiter degenerates to gnt = req & init_done.

Optional Feature:
- Macro MC_RR_MEM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte and recomputed on every written byte.
  - The init sweep writes the parity matching INIT_VAL.
  - Extra output perr (DATA_WIDTH/8 bits) is registered alongside rdata and valid with rvalid.
  - Each perr bit is high if the stored parity mismatches the recomputed parity of that byte.
  - perr resets to 0.
- Undefined: no parity storage and no perr port.

Decomposition:
- Package mc_pkg holds:
  - FSM state enum (INIT, RUN).
  - Localparams for byte-lane count (DATA_WIDTH/8) and depth.
  - A function for the round-robin next-pointer.
- One sub-module, mc_rr_arb:
  - Parameterised by NUM_CH.
  - Inputs: req, enable. Output: one-hot gnt.
  - Holds the registered rr pointer.
  - Reusable by other shared-resource blocks.

Test Plan:
- Reset release with ADDR_WIDTH=4 -> init_done rises after exactly 16 cycles; reading all 16 addresses returns 0xFFFFFFFF with rvalid one cycle after each gnt.
- Request during INIT (ch0 read addr 3 at cycle 2) -> gnt stays 0 until init_done; then grant, and rdata=0xFFFFFFFF.
- Byte-enable write: ch1 writes addr 5, wdata=0x11223344, be=4'b0101 -> read addr 5 returns 0xFF22FF44.
- Round-robin fairness: ch0 and ch1 both hold req continuously -> gnt alternates 01,10,01,10; after the last grant to ch1, only ch0 requests -> ch0 granted immediately.
- Write addr 7 = 0xA5A5A5A5 then read addr 7 on the next cycle -> rdata=0xA5A5A5A5; reset asserted while rvalid is pending -> rvalid=0, init_done=0, and the sweep restarts.
- With MC_RR_MEM_PARITY_EN: force-flip one stored bit of byte 2 at addr 9 via hierarchical access, then read addr 9 -> perr=4'b0100 with rvalid.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and helpers for the round-robin multi-channel memory controller.
// Holds the FSM state enum, default geometry and the round-robin/parity helper functions.
package mc_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } mc_state_e;

    localparam int MC_DEF_ADDR_WIDTH = 4;
    localparam int MC_DEF_DATA_WIDTH = 32;
    localparam int MC_DEF_NUM_CH     = 2;

    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int mem_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Pointer moves one past the granted channel, wrapping after the last one.
    function automatic int rr_next_ptr(input int gidx, input int num_ch);
        return (gidx >= num_ch - 1) ? 0 : gidx + 1;
    endfunction

    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/mc_rr_arb.sv
// Round-robin arbiter with a registered priority pointer; grant is combinational.
// Reusable for any shared resource: enable gates all grants without moving the pointer.
module mc_rr_arb
    import mc_pkg::*;
#(
    parameter int NUM_CH = MC_DEF_NUM_CH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              enable,
    output logic [NUM_CH-1:0] gnt
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0]  ptr_r;
    logic [PTR_W-1:0]  idx_s;
    logic [PTR_W-1:0]  gidx_s;
    logic [NUM_CH-1:0] gnt_s;
    logic              hit_s;
    logic              found_s;

    // Search upward from the pointer with wrap; the first requester wins.
    always_comb begin
        gnt_s   = '0;
        found_s = 1'b0;
        gidx_s  = ptr_r;
        idx_s   = ptr_r;
        hit_s   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx_s         = PTR_W'((int'(ptr_r) + i) % NUM_CH);
            hit_s         = enable & req[idx_s] & ~found_s;
            gnt_s[idx_s]  = gnt_s[idx_s] | hit_s;
            gidx_s        = hit_s ? idx_s : gidx_s;
            found_s       = found_s | hit_s;
        end
    end

    // Priority pointer advances only when a grant is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (found_s) begin
            ptr_r <= PTR_W'(rr_next_ptr(int'(gidx_s), NUM_CH));
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/mc_rr_mem.sv
// Multi-channel single-port register-array memory with round-robin arbitration and init sweep.
// Optional macro MC_RR_MEM_PARITY_EN adds per-byte even parity storage and a perr output.
module mc_rr_mem
    import mc_pkg::*;
#(
    parameter int                    ADDR_WIDTH = MC_DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = MC_DEF_DATA_WIDTH,
    parameter int                    NUM_CH     = MC_DEF_NUM_CH,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = {DATA_WIDTH{1'b1}}
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CH-1:0]                req,
    input  logic [NUM_CH-1:0]                we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]     addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]     wdata,
    input  logic [NUM_CH*(DATA_WIDTH/8)-1:0] be,
    output logic [NUM_CH-1:0]                gnt,
    output logic [NUM_CH-1:0]                rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
`ifdef MC_RR_MEM_PARITY_EN
    output logic [DATA_WIDTH/8-1:0]          perr,
`endif
    output logic                             init_done
);

    localparam int NB    = lane_count(DATA_WIDTH);
    localparam int DEPTH = mem_depth(ADDR_WIDTH);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    mc_state_e             state_r, state_s;
    logic [ADDR_WIDTH-1:0] init_cnt_r, init_cnt_s;
    logic                  init_wr_s;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [NUM_CH-1:0]     gnt_s;
    logic [SEL_W-1:0]      sel_idx_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;
    logic [NB-1:0]         sel_be_s;
    logic                  sel_we_s;
    logic                  wr_s;
    logic                  rd_s;
    logic [NUM_CH-1:0]     rvalid_r;
    logic [DATA_WIDTH-1:0] rdata_r;

    mc_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .enable (state_r == ST_RUN),
        .gnt    (gnt_s)
    );

    // Init sweep FSM: one INIT_VAL write per cycle, then RUN until reset.
    always_comb begin
        state_s    = state_r;
        init_cnt_s = init_cnt_r;
        init_wr_s  = 1'b0;
        case (state_r)
            ST_INIT: begin
                init_wr_s  = 1'b1;
                init_cnt_s = init_cnt_r + ADDR_WIDTH'(1);
                if (&init_cnt_r) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_RUN:  state_s = ST_RUN;
            default: state_s = ST_INIT;
        endcase
    end

    // FSM state and sweep address registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_INIT;
            init_cnt_r <= '0;
        end else begin
            state_r    <= state_s;
            init_cnt_r <= init_cnt_s;
        end
    end

    // Steer the granted channel's request fields onto the single memory port.
    always_comb begin
        sel_idx_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_idx_s = gnt_s[i] ? SEL_W'(i) : sel_idx_s;
        end
        sel_addr_s  = addr[int'(sel_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_s = wdata[int'(sel_idx_s)*DATA_WIDTH +: DATA_WIDTH];
        sel_be_s    = be[int'(sel_idx_s)*NB +: NB];
        sel_we_s    = we[sel_idx_s];
        wr_s        = (|gnt_s) & sel_we_s;
        rd_s        = (|gnt_s) & ~sel_we_s;
    end

`ifdef MC_RR_MEM_PARITY_EN
    logic [NB-1:0] par_r [DEPTH];
    logic [NB-1:0] perr_s, perr_r, init_par_s;

    // Recompute parity of the addressed word and flag lanes that disagree with storage.
    always_comb begin
        perr_s     = '0;
        init_par_s = '0;
        for (int k = 0; k < NB; k++) begin
            perr_s[k]     = par_r[sel_addr_s][k] ^ byte_parity(mem_r[sel_addr_s][k*8 +: 8]);
            init_par_s[k] = byte_parity(INIT_VAL[k*8 +: 8]);
        end
    end
`endif

    // Storage array: no reset, filled by the sweep; byte-masked writes in RUN.
    always_ff @(posedge clk) begin
        if (init_wr_s) begin
            mem_r[init_cnt_r] <= INIT_VAL;
`ifdef MC_RR_MEM_PARITY_EN
            par_r[init_cnt_r] <= init_par_s;
`endif
        end else if (wr_s) begin
            for (int k = 0; k < NB; k++) begin
                if (sel_be_s[k]) begin
                    mem_r[sel_addr_s][k*8 +: 8] <= sel_wdata_s[k*8 +: 8];
`ifdef MC_RR_MEM_PARITY_EN
                    par_r[sel_addr_s][k] <= byte_parity(sel_wdata_s[k*8 +: 8]);
`endif
                end
            end
        end
    end

    // Registered read response; rdata holds between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_r <= '0;
            rdata_r  <= '0;
`ifdef MC_RR_MEM_PARITY_EN
            perr_r   <= '0;
`endif
        end else begin
            rvalid_r <= rd_s ? gnt_s : '0;
            if (rd_s) begin
                rdata_r <= mem_r[sel_addr_s];
`ifdef MC_RR_MEM_PARITY_EN
                perr_r  <= perr_s;
`endif
            end
        end
    end

    assign gnt       = gnt_s;
    assign rvalid    = rvalid_r;
    assign rdata     = rdata_r;
    assign init_done = (state_r == ST_RUN);
`ifdef MC_RR_MEM_PARITY_EN
    assign perr      = perr_r;
`endif

endmodule

// File: tb/tb_mc_rr_mem.sv
// Self-checking bench for mc_rr_mem: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural memory/arbiter model.
module tb_mc_rr_mem;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NC    = 2;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NC-1:0]    req = '0;
    logic [NC-1:0]    we = '0;
    logic [NC*AW-1:0] addr = '0;
    logic [NC*DW-1:0] wdata = '0;
    logic [NC*NB-1:0] be = '0;
    logic [NC-1:0]    gnt;
    logic [NC-1:0]    rvalid;
    logic [DW-1:0]    rdata;
    logic             init_done;
`ifdef MC_RR_MEM_PARITY_EN
    logic [NB-1:0]    perr;
    logic [NB-1:0]    flip_m [DEPTH];
    logic [NB-1:0]    exp_perr = '0;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [DW-1:0] mem_m [DEPTH];
    int            init_left = DEPTH;
    int            rr_m = 0;
    logic [NC-1:0] exp_rv = '0;
    logic [DW-1:0] exp_rd = '0;

    mc_rr_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .be        (be),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
`ifdef MC_RR_MEM_PARITY_EN
        .perr      (perr),
`endif
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // First requesting channel at or after the pointer, or -1.
    function automatic int pick(input logic [NC-1:0] r, input int p);
        for (int k = 0; k < NC; k++) begin
            if (r[(p + k) % NC]) return (p + k) % NC;
        end
        return -1;
    endfunction

    // Compare DUT against the model, then advance the model past the coming edge.
    always @(negedge clk) begin
        int            c;
        int            a;
        logic [NC-1:0] eg;
        if (reset) begin
            chk("reset_gnt", gnt, 0);
            chk("reset_rvalid", rvalid, 0);
            chk("reset_rdata", rdata, 0);
            chk("reset_init_done", init_done, 0);
            init_left = DEPTH;
            rr_m      = 0;
            exp_rv    = '0;
            exp_rd    = '0;
`ifdef MC_RR_MEM_PARITY_EN
            exp_perr  = '0;
`endif
        end else begin
            c  = (init_left == 0) ? pick(req, rr_m) : -1;
            eg = '0;
            if (c >= 0) eg[c] = 1'b1;
            chk("gnt", gnt, eg);
            chk("rvalid", rvalid, exp_rv);
            chk("rdata", rdata, exp_rd);
            chk("init_done", init_done, (init_left == 0) ? 1 : 0);
`ifdef MC_RR_MEM_PARITY_EN
            chk("perr", perr, exp_perr);
`endif
            exp_rv = '0;
            if (init_left > 0) begin
                mem_m[DEPTH - init_left] = '1;
`ifdef MC_RR_MEM_PARITY_EN
                flip_m[DEPTH - init_left] = '0;
`endif
                init_left--;
            end else if (c >= 0) begin
                a = int'(addr[c*AW +: AW]);
                if (we[c]) begin
                    for (int k = 0; k < NB; k++) begin
                        if (be[c*NB + k]) begin
                            mem_m[a][k*8 +: 8] = wdata[c*DW + k*8 +: 8];
`ifdef MC_RR_MEM_PARITY_EN
                            flip_m[a][k] = 1'b0;
`endif
                        end
                    end
                end else begin
                    exp_rv = eg;
                    exp_rd = mem_m[a];
`ifdef MC_RR_MEM_PARITY_EN
                    exp_perr = flip_m[a];
`endif
                end
                rr_m = (c + 1) % NC;
            end
        end
    end

    task automatic set_ch(input int ch, input logic w, input int a,
                          input logic [DW-1:0] d, input logic [NB-1:0] b);
        we[ch]            = w;
        addr[ch*AW +: AW] = AW'(a);
        wdata[ch*DW +: DW] = d;
        be[ch*NB +: NB]    = b;
    endtask

    // Issue one request on ch, hold it until granted, return rdata sampled after the grant edge.
    task automatic do_access(input int ch, input logic w, input int a, input logic [DW-1:0] d,
                             input logic [NB-1:0] b, output logic [DW-1:0] rd);
        logic granted;
        int   n;
        set_ch(ch, w, a, d, b);
        req[ch] = 1'b1;
        n = 0;
        granted = 1'b0;
        while (!granted && n < 100) begin
            @(negedge clk);
            granted = gnt[ch];
            @(posedge clk);
            #1;
            n++;
        end
        req[ch] = 1'b0;
        chk("access_granted", granted, 1);
        rd = rdata;
        if (!w) chk("rvalid_after_gnt", rvalid[ch], 1);
    endtask

    task automatic wait_init(input string nm);
        int n;
        n = 0;
        while (!init_done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 2) begin
                set_ch(0, 1'b0, 3, '0, '0);
                req[0] = 1'b1;
            end
        end
        chk(nm, n, 16);
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic [NC-1:0] seq [4];

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Sweep length, plus a ch0 read of addr 3 raised during INIT
        wait_init("init_cycles");
        @(negedge clk);
        chk("held_req_gnt", gnt, 2'b01);
        @(posedge clk);
        #1 req = '0;
        chk("held_req_rvalid", rvalid, 2'b01);
        chk("held_req_rdata", rdata, 32'hFFFF_FFFF);

        for (int a = 0; a < DEPTH; a++) begin
            do_access(a % NC, 1'b0, a, '0, '0, rd);
            chk("sweep_val", rd, 32'hFFFF_FFFF);
        end

        // Byte-enable write, then read back from the other channel
        do_access(1, 1'b1, 5, 32'h1122_3344, 4'b0101, rd);
        do_access(0, 1'b0, 5, '0, '0, rd);
        chk("be_merge", rd, 32'hFF22_FF44);
        do_access(1, 1'b0, 0, '0, '0, rd);

        // Both channels request continuously: grants must alternate starting at ch0
        set_ch(0, 1'b0, 1, '0, '0);
        set_ch(1, 1'b0, 2, '0, '0);
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seq[i] = gnt;
            @(posedge clk);
            #1;
        end
        req = 2'b01;
        chk("rr_0", seq[0], 2'b01);
        chk("rr_1", seq[1], 2'b10);
        chk("rr_2", seq[2], 2'b01);
        chk("rr_3", seq[3], 2'b10);
        @(negedge clk);
        chk("rr_lone_ch0", gnt, 2'b01);
        @(posedge clk);
        #1 req = '0;

        // Write then immediate read-back
        do_access(0, 1'b1, 7, 32'hA5A5_A5A5, 4'b1111, rd);
        do_access(0, 1'b0, 7, '0, '0, rd);
        chk("wr_then_rd", rd, 32'hA5A5_A5A5);

        // Reset while a read response is outstanding
        do_access(1, 1'b0, 7, '0, '0, rd);
        reset = 1'b1;
        #1;
        chk("midreset_rvalid", rvalid, 2'b00);
        chk("midreset_init_done", init_done, 1'b0);
        chk("midreset_rdata", rdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_init("reinit_cycles");
        @(posedge clk);
        #1 req = '0;

`ifdef MC_RR_MEM_PARITY_EN
        dut.mem_r[9][16] = ~dut.mem_r[9][16];
        mem_m[9][16]     = ~mem_m[9][16];
        flip_m[9]        = 4'b0100;
        do_access(0, 1'b0, 9, '0, '0, rd);
        chk("perr_flip", perr, 4'b0100);
`endif

        // Randomized traffic; the per-cycle compare process checks every response
        for (int i = 0; i < 3000; i++) begin
            req   = NC'($urandom);
            we    = NC'($urandom);
            addr  = (NC*AW)'($urandom);
            wdata = {$urandom, $urandom};
            be    = (NC*NB)'($urandom);
            @(posedge clk);
            #1;
        end
        req = '0;
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
